// File: rtl/nbit_register_file_mp.sv
// nbit_register_file_mp
//   Multi-port register file with write-to-read bypass, an optional hardwired
//   zero register, a selectable reset image and a per-register pending
//   scoreboard for tracking in-flight producers.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   RegWrite        write enable per write port
//   write_address   port k at [k*select_width +: select_width]
//   write_data      port k at [k*data_width +: data_width]
//   read_sel        read port p select, same slicing as write_address
//   read_data       read port p data (combinational, bypassed)
//   reserve_en      mark reserve_address pending
//   reserve_address destination register being issued
//   read_pending    pending status as seen by read port p (bypass-aware)
//   pending         registered scoreboard vector, one bit per register
//   write_conflict  registered: enabled write ports collided last cycle
module nbit_register_file_mp #(
  parameter int unsigned data_width   = 32,
  parameter int unsigned select_width = 5,
  parameter int unsigned num_read     = 2,
  parameter int unsigned num_write    = 2,
  parameter int unsigned zero_reg     = 1,
  parameter int unsigned reset_init   = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [num_write-1:0]             RegWrite,
  input  logic [num_write*select_width-1:0] write_address,
  input  logic [num_write*data_width-1:0]  write_data,
  input  logic [num_read*select_width-1:0] read_sel,
  output logic [num_read*data_width-1:0]   read_data,
  input  logic                             reserve_en,
  input  logic [select_width-1:0]          reserve_address,
  output logic [num_read-1:0]              read_pending,
  output logic [(2**select_width)-1:0]     pending,
  output logic                             write_conflict
);

  localparam int unsigned depth = 2**select_width;

  logic [data_width-1:0]   regs [depth];
  logic [select_width-1:0] waddr [num_write];
  logic [num_write-1:0]    wr_valid;
  logic [depth-1:0]        pending_next;
  logic                    conflict_next;

  function automatic logic [data_width-1:0] reset_value(input int unsigned idx);
    logic [data_width-1:0] v;
    v = '0;
    if (reset_init != 0) v = data_width'(10 * idx);
    if (zero_reg != 0 && idx == 0) v = '0;
    return v;
  endfunction

  // Writes to register 0 are dropped entirely when it is hardwired, so they
  // neither bypass, clear pending, nor count towards a collision.
  always_comb begin
    wr_valid = '0;
    for (int unsigned k = 0; k < num_write; k++) begin
      waddr[k]    = write_address[k*select_width +: select_width];
      wr_valid[k] = RegWrite[k] && !(zero_reg != 0 && waddr[k] == '0);
    end
  end

  always_comb begin
    conflict_next = 1'b0;
    for (int unsigned k = 1; k < num_write; k++)
      for (int unsigned j = 0; j < k; j++)
        if (wr_valid[k] && wr_valid[j] && waddr[k] == waddr[j])
          conflict_next = 1'b1;
  end

  // Write clears are applied first so a same-cycle reservation overrides them.
  always_comb begin
    pending_next = pending;
    for (int unsigned k = 0; k < num_write; k++)
      if (wr_valid[k]) pending_next[waddr[k]] = 1'b0;
    if (reserve_en && !(zero_reg != 0 && reserve_address == '0))
      pending_next[reserve_address] = 1'b1;
  end

  // Ascending port order: the highest-index colliding port lands last and wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < depth; i++) regs[i] <= reset_value(i);
    end else begin
      for (int unsigned k = 0; k < num_write; k++)
        if (wr_valid[k]) regs[waddr[k]] <= write_data[k*data_width +: data_width];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending        <= '0;
      write_conflict <= 1'b0;
    end else begin
      pending        <= pending_next;
      write_conflict <= conflict_next;
    end
  end

  always_comb begin
    logic [select_width-1:0] sel;
    logic [data_width-1:0]   val;
    logic                    byp;
    read_data    = '0;
    read_pending = '0;
    sel          = '0;
    val          = '0;
    byp          = 1'b0;
    for (int unsigned p = 0; p < num_read; p++) begin
      sel = read_sel[p*select_width +: select_width];
      val = regs[sel];
      byp = 1'b0;
      for (int unsigned k = 0; k < num_write; k++) begin
        if (wr_valid[k] && waddr[k] == sel) begin
          val = write_data[k*data_width +: data_width];
          byp = 1'b1;
        end
      end
      if (zero_reg != 0 && sel == '0) val = '0;
      read_data[p*data_width +: data_width] = val;
      read_pending[p] = pending[sel] & ~byp;
    end
  end

endmodule

// File: tb/tb_nbit_register_file_mp.sv
module tb_nbit_register_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  RegWrite;
  logic [9:0]  write_address;
  logic [63:0] write_data;
  logic [9:0]  read_sel;
  logic        reserve_en;
  logic [4:0]  reserve_address;

  logic [63:0] read_data, read_data_z;
  logic [1:0]  read_pending, read_pending_z;
  logic [31:0] pending, pending_z;
  logic        write_conflict, write_conflict_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nbit_register_file_mp #(.data_width(32), .select_width(5), .num_read(2),
    .num_write(2), .zero_reg(1), .reset_init(1)) dut (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .write_address(write_address),
    .write_data(write_data), .read_sel(read_sel), .read_data(read_data),
    .reserve_en(reserve_en), .reserve_address(reserve_address),
    .read_pending(read_pending), .pending(pending), .write_conflict(write_conflict));

  nbit_register_file_mp #(.data_width(32), .select_width(5), .num_read(2),
    .num_write(2), .zero_reg(1), .reset_init(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .write_address(write_address),
    .write_data(write_data), .read_sel(read_sel), .read_data(read_data_z),
    .reserve_en(reserve_en), .reserve_address(reserve_address),
    .read_pending(read_pending_z), .pending(pending_z), .write_conflict(write_conflict_z));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    RegWrite   = 2'b00;
    reserve_en = 1'b0;
  endtask

  // Inputs change on the falling edge; checks happen 1 time unit later.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; RegWrite = '0; write_address = '0; write_data = '0;
    read_sel = {5'd31, 5'd3}; reserve_en = 1'b0; reserve_address = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_img_r3",   read_data[31:0],  64'd30);
    check("rst_img_r31",  read_data[63:32], 64'd310);
    check("rst_pending",  pending,          64'd0);
    check("rst_conflict", write_conflict,   64'd0);
    check("rst_zero_img", read_data_z,      64'd0);

    // Write with same-cycle bypass, then stored read.
    @(negedge clk);
    RegWrite = 2'b01; write_address[4:0] = 5'd5; write_data[31:0] = 32'hDEADBEEF;
    read_sel = {5'd3, 5'd5};
    #1;
    check("bypass_r5", read_data[31:0],  64'hDEADBEEF);
    check("plain_r3",  read_data[63:32], 64'd30);
    step(); idle(); #1;
    check("stored_r5", read_data[31:0], 64'hDEADBEEF);

    // Zero register ignores writes and reservations.
    @(negedge clk);
    RegWrite = 2'b01; write_address[4:0] = 5'd0; write_data[31:0] = 32'h1234;
    reserve_en = 1'b1; reserve_address = 5'd0; read_sel = {5'd3, 5'd0};
    #1;
    check("zero_bypass", read_data[31:0], 64'd0);
    check("zero_rdpend", read_pending[0], 64'd0);
    step(); idle(); #1;
    check("zero_stored",  read_data[31:0], 64'd0);
    check("zero_pending", pending,         64'd0);

    // Collision on address 7: port 1 wins, conflict pulses for one cycle.
    @(negedge clk);
    RegWrite = 2'b11; write_address = {5'd7, 5'd7}; write_data = {32'h22, 32'h11};
    read_sel = {5'd3, 5'd7};
    #1;
    check("coll_bypass",  read_data[31:0], 64'h22);
    check("coll_flag_pre", write_conflict, 64'd0);
    step(); idle(); #1;
    check("coll_stored", read_data[31:0], 64'h22);
    check("coll_flag",   write_conflict,  64'd1);
    step(); #1;
    check("coll_flag_off", write_conflict, 64'd0);

    // Scoreboard: reserve 9, then retire via port 1.
    @(negedge clk);
    reserve_en = 1'b1; reserve_address = 5'd9;
    step(); idle(); read_sel = {5'd3, 5'd9}; #1;
    check("sb_pending9",  pending[9],      64'd1);
    check("sb_rdpend0",   read_pending[0], 64'd1);
    check("sb_rdpend1",   read_pending[1], 64'd0);
    @(negedge clk);
    RegWrite = 2'b10; write_address[9:5] = 5'd9; write_data[63:32] = 32'h99;
    #1;
    check("sb_rdpend_byp", read_pending[0], 64'd0);
    check("sb_data_byp",   read_data[31:0], 64'h99);
    step(); idle(); #1;
    check("sb_cleared", pending, 64'd0);

    // Reservation beats same-cycle write to the same register.
    @(negedge clk);
    reserve_en = 1'b1; reserve_address = 5'd9;
    RegWrite = 2'b01; write_address[4:0] = 5'd9; write_data[31:0] = 32'h55;
    #1;
    check("sb_race_rdpend", read_pending[0], 64'd0);
    step(); idle(); #1;
    check("sb_race_pending", pending,         64'h200);
    check("sb_race_data",    read_data[31:0], 64'h55);

    // Async reset between edges: clears state immediately, drops the write.
    @(negedge clk);
    RegWrite = 2'b01; write_address[4:0] = 5'd4; write_data[31:0] = 32'hAA;
    step(); idle(); read_sel = {5'd4, 5'd9}; #1;
    check("ar_r4_before", read_data[63:32], 64'hAA);
    @(negedge clk);
    RegWrite = 2'b01; write_address[4:0] = 5'd4; write_data[31:0] = 32'hBB;
    #2 rst_n = 1'b0;
    #1;
    check("ar_pending", pending, 64'd0);
    idle(); #1;
    check("ar_r4_now", read_data[63:32], 64'd40);
    check("ar_r9_now", read_data[31:0],  64'd90);
    check("ar_zero_r4", read_data_z[63:32], 64'd0);
    RegWrite = 2'b01;
    @(posedge clk);
    @(negedge clk);
    idle(); rst_n = 1'b1; #1;
    check("ar_write_lost", read_data[63:32], 64'd40);
    @(negedge clk);
    RegWrite = 2'b01; write_address[4:0] = 5'd4; write_data[31:0] = 32'hCC;
    step(); idle(); #1;
    check("post_rst_write", read_data[63:32], 64'hCC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
